// File: rtl/vec_chunk_fifo_pkg.sv
// Shared types and sizing helpers for the vector-granular chunk FIFO.
package vec_chunk_fifo_pkg;
  localparam int WORKING_REGS = 4;

  typedef logic signed [7:0] elem_t;
  typedef elem_t [WORKING_REGS-1:0] chunk_t;

  function automatic int chunks_per_vec(input int in_vec_length, input int working_regs);
    return in_vec_length / working_regs;
  endfunction
endpackage

// File: rtl/vec_chunk_fifo_if.sv
// Producer/consumer bundle of the chunk FIFO; master = pipeline stages, slave = FIFO.
interface vec_chunk_fifo_if
  import vec_chunk_fifo_pkg::*;
#(
  parameter int WorkingRegs = WORKING_REGS,
  parameter int VecDepth    = 2
);
  localparam int VcW = $clog2(VecDepth + 1);

  logic                    wr_chunk_valid;
  elem_t [WorkingRegs-1:0] wr_data;
  logic                    wr_abort;
  logic                    wr_ready;
  logic                    rd_req_chunk;
  elem_t [WorkingRegs-1:0] rd_data;
  logic                    rd_data_ready;
  logic                    rd_last_chunk;
  logic [VcW-1:0]          vec_count;
  logic                    wr_overflow;
  logic                    rd_underflow;

  modport master (
    output wr_chunk_valid, wr_data, wr_abort, rd_req_chunk,
    input  wr_ready, rd_data, rd_data_ready, rd_last_chunk, vec_count, wr_overflow, rd_underflow
  );

  modport slave (
    input  wr_chunk_valid, wr_data, wr_abort, rd_req_chunk,
    output wr_ready, rd_data, rd_data_ready, rd_last_chunk, vec_count, wr_overflow, rd_underflow
  );
endinterface

// File: rtl/vec_chunk_ram.sv
// Simple dual-port chunk store: synchronous write, asynchronous read (distributed RAM).
module vec_chunk_ram #(
  parameter int Depth = 8,
  parameter int Width = 32,
  parameter int AddrW = 3
) (
  input  logic             clk_in,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/vec_chunk_fifo.sv
// Chunk FIFO that only exposes a vector to the reader once every chunk of it is written;
// a partially written vector can be aborted and rolled back to its base slot.
module vec_chunk_fifo
  import vec_chunk_fifo_pkg::*;
#(
  parameter int InVecLength = 64,
  parameter int WorkingRegs = WORKING_REGS,
  parameter int VecDepth    = 2
) (
  input  logic            clk_in,
  input  logic            rst_in_n,
  vec_chunk_fifo_if.slave bus
);
  localparam int Cpv    = chunks_per_vec(InVecLength, WorkingRegs);
  localparam int Cap    = VecDepth * Cpv;
  localparam int PtrW   = (Cap > 1) ? $clog2(Cap) : 1;
  localparam int IdxW   = (Cpv > 1) ? $clog2(Cpv) : 1;
  localparam int OccW   = $clog2(Cap + 1);
  localparam int VcW    = $clog2(VecDepth + 1);
  localparam int ChunkW = WorkingRegs * 8;

  localparam logic [PtrW-1:0] PtrLast = PtrW'(Cap - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Cpv - 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_vec_base_q, wr_vec_base_d;
  logic [IdxW-1:0] wr_chunk_idx_q, wr_chunk_idx_d, rd_chunk_idx_q, rd_chunk_idx_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic [VcW-1:0]  vec_count_q, vec_count_d;
  logic            wr_overflow_q, wr_overflow_d, rd_underflow_q, rd_underflow_d;

  logic              wr_ready, have_vec, push, pop, commit, last_pop;
  logic [ChunkW-1:0] ram_rd_data;

  // Pointers wrap at Cap, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ready = occ_q < OccW'(Cap);
    have_vec = vec_count_q != '0;
    push     = bus.wr_chunk_valid && wr_ready && !bus.wr_abort;
    pop      = bus.rd_req_chunk && have_vec;
    commit   = push && (wr_chunk_idx_q == IdxLast);
    last_pop = pop && (rd_chunk_idx_q == IdxLast);
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    wr_chunk_idx_d = wr_chunk_idx_q;
    wr_vec_base_d  = wr_vec_base_q;
    if (bus.wr_abort) begin
      wr_ptr_d       = wr_vec_base_q;
      wr_chunk_idx_d = '0;
    end else if (push) begin
      wr_ptr_d       = ptr_inc(wr_ptr_q);
      wr_chunk_idx_d = commit ? '0 : wr_chunk_idx_q + IdxW'(1);
      if (commit) wr_vec_base_d = ptr_inc(wr_ptr_q);
    end

    rd_ptr_d       = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    rd_chunk_idx_d = rd_chunk_idx_q;
    if (pop) rd_chunk_idx_d = last_pop ? '0 : rd_chunk_idx_q + IdxW'(1);

    // Abort rolls back only the uncommitted chunks of the vector in flight.
    occ_d = occ_q - (bus.wr_abort ? OccW'(wr_chunk_idx_q) : '0)
                  + OccW'(push) - OccW'(pop);
    vec_count_d = vec_count_q + VcW'(commit) - VcW'(last_pop);

    wr_overflow_d  = wr_overflow_q || (bus.wr_chunk_valid && !wr_ready && !bus.wr_abort);
    rd_underflow_d = rd_underflow_q || (bus.rd_req_chunk && !have_vec);
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_vec_base_q  <= '0;
      wr_chunk_idx_q <= '0;
      rd_chunk_idx_q <= '0;
      occ_q          <= '0;
      vec_count_q    <= '0;
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_vec_base_q  <= wr_vec_base_d;
      wr_chunk_idx_q <= wr_chunk_idx_d;
      rd_chunk_idx_q <= rd_chunk_idx_d;
      occ_q          <= occ_d;
      vec_count_q    <= vec_count_d;
      wr_overflow_q  <= wr_overflow_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  vec_chunk_ram #(
    .Depth (Cap),
    .Width (ChunkW),
    .AddrW (PtrW)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_data_ready = have_vec;
  assign bus.rd_data       = have_vec ? ram_rd_data : '0;
  assign bus.rd_last_chunk = have_vec && (rd_chunk_idx_q == IdxLast);
  assign bus.vec_count     = vec_count_q;
  assign bus.wr_overflow   = wr_overflow_q;
  assign bus.rd_underflow  = rd_underflow_q;
endmodule
